// File: rtl/fpu_f2i_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fpu_f2i_if
// Purpose  : Operand/result bundle for the float-to-int converter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface fpu_f2i_if;
    logic        IN_VALID;
    logic [31:0] A;
    logic        CLR_FLAGS;
    logic        OUT_VALID;
    logic [31:0] Z;
    logic        INVALID;
    logic        INEXACT;
    logic        STICKY_INV;
    logic        STICKY_INX;

    modport master (
        output IN_VALID, A, CLR_FLAGS,
        input  OUT_VALID, Z, INVALID, INEXACT, STICKY_INV, STICKY_INX
    );

    modport slave (
        input  IN_VALID, A, CLR_FLAGS,
        output OUT_VALID, Z, INVALID, INEXACT, STICKY_INV, STICKY_INX
    );
endinterface
`default_nettype wire

// File: rtl/fpu_f2i.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fpu_f2i
// Purpose  : 3-stage IEEE-754 single to signed 32-bit integer converter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module fpu_f2i #(
    parameter int RNE    = 1,
    parameter int STAGES = 3
) (
    input  wire logic  CLK,
    input  wire logic  RESET,
    fpu_f2i_if.slave   bus
);

    generate
        if (STAGES != 3) begin : g_bad_stages
            $error("fpu_f2i: STAGES must be 3");
        end
    endgenerate

    localparam logic [31:0] c_pos_sat = 32'h7FFF_FFFF;
    localparam logic [31:0] c_neg_sat = 32'h8000_0000;
    localparam logic [32:0] c_two31   = 33'h0_8000_0000;

    // ---------------- stage 1: unpack ----------------
    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q,  s1_sign_d;
    logic [7:0]  s1_exp_q,   s1_exp_d;
    logic [23:0] s1_sig_q,   s1_sig_d;

    always_comb begin
        s1_valid_d = bus.IN_VALID;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_sig_d   = s1_sig_q;
        if (bus.IN_VALID) begin
            s1_sign_d = bus.A[31];
            s1_exp_d  = bus.A[30:23];
            s1_sig_d  = {1'b1, bus.A[22:0]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= 8'd0;
            s1_sig_q   <= 24'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_sig_q   <= s1_sig_d;
        end
    end

    // ---------------- stage 2: align and round ----------------
    logic signed [8:0] w_u;
    logic [4:0]  w_rsh;
    logic [3:0]  w_lsh;
    logic [47:0] w_ext;
    logic [31:0] w_int;
    logic        w_guard;
    logic        w_sticky;
    logic        w_big;
    logic        w_inc;
    logic [32:0] w_mag;

    always_comb begin
        w_u      = $signed({1'b0, s1_exp_q}) - 9'sd127;
        // shift distances expressed on the biased exponent (150 = 127 + 23)
        w_rsh    = 5'(8'd150 - s1_exp_q);
        w_lsh    = 4'(s1_exp_q - 8'd150);
        w_ext    = 48'd0;
        w_int    = 32'd0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        // anything at or above 2^32 is caught here so the left shift never wraps
        w_big    = (w_u >= 9'sd32);
        if (w_big) begin
            w_int = 32'd0;
        end else if (w_u >= 9'sd23) begin
            w_int = {8'd0, s1_sig_q} << w_lsh;
        end else if (w_u >= 9'sd0) begin
            w_ext    = {s1_sig_q, 24'd0} >> w_rsh;
            w_int    = {8'd0, w_ext[47:24]};
            w_guard  = w_ext[23];
            w_sticky = |w_ext[22:0];
        end else if (w_u == -9'sd1) begin
            w_guard  = 1'b1;
            w_sticky = |s1_sig_q[22:0];
        end else begin
            w_sticky = 1'b1;
        end
        w_inc = (RNE != 0) && w_guard && (w_sticky || w_int[0]);
        w_mag = {1'b0, w_int} + {32'd0, w_inc};
    end

    logic        s2_valid_q, s2_valid_d;
    logic        s2_sign_q,  s2_sign_d;
    logic        s2_zero_q,  s2_zero_d;
    logic        s2_nan_q,   s2_nan_d;
    logic        s2_inf_q,   s2_inf_d;
    logic        s2_big_q,   s2_big_d;
    logic        s2_inx_q,   s2_inx_d;
    logic [32:0] s2_mag_q,   s2_mag_d;

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_zero_d  = s2_zero_q;
        s2_nan_d   = s2_nan_q;
        s2_inf_d   = s2_inf_q;
        s2_big_d   = s2_big_q;
        s2_inx_d   = s2_inx_q;
        s2_mag_d   = s2_mag_q;
        if (s1_valid_q) begin
            s2_sign_d = s1_sign_q;
            s2_zero_d = (s1_exp_q == 8'd0);
            s2_nan_d  = (s1_exp_q == 8'hFF) && (s1_sig_q[22:0] != 23'd0);
            s2_inf_d  = (s1_exp_q == 8'hFF) && (s1_sig_q[22:0] == 23'd0);
            s2_big_d  = w_big;
            s2_inx_d  = w_guard | w_sticky;
            s2_mag_d  = w_mag;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_nan_q   <= 1'b0;
            s2_inf_q   <= 1'b0;
            s2_big_q   <= 1'b0;
            s2_inx_q   <= 1'b0;
            s2_mag_q   <= 33'd0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_zero_q  <= s2_zero_d;
            s2_nan_q   <= s2_nan_d;
            s2_inf_q   <= s2_inf_d;
            s2_big_q   <= s2_big_d;
            s2_inx_q   <= s2_inx_d;
            s2_mag_q   <= s2_mag_d;
        end
    end

    // ---------------- stage 3: range check, negate, flags ----------------
    logic        out_valid_q,  out_valid_d;
    logic [31:0] z_q,          z_d;
    logic        invalid_q,    invalid_d;
    logic        inexact_q,    inexact_d;
    logic        sticky_inv_q, sticky_inv_d;
    logic        sticky_inx_q, sticky_inx_d;

    always_comb begin
        out_valid_d = s2_valid_q;
        z_d         = z_q;
        invalid_d   = invalid_q;
        inexact_d   = inexact_q;
        if (s2_valid_q) begin
            invalid_d = 1'b0;
            inexact_d = 1'b0;
            if (s2_zero_q) begin
                z_d = 32'd0;
            end else if (s2_nan_q) begin
                z_d       = c_pos_sat;
                invalid_d = 1'b1;
            end else if (s2_inf_q || s2_big_q) begin
                z_d       = s2_sign_q ? c_neg_sat : c_pos_sat;
                invalid_d = 1'b1;
            end else if (!s2_sign_q && (s2_mag_q >= c_two31)) begin
                z_d       = c_pos_sat;
                invalid_d = 1'b1;
            end else if (s2_sign_q && (s2_mag_q > c_two31)) begin
                z_d       = c_neg_sat;
                invalid_d = 1'b1;
            end else begin
                // a negative magnitude of exactly 2^31 negates to 0x80000000 here
                z_d       = s2_sign_q ? (~s2_mag_q[31:0] + 32'd1) : s2_mag_q[31:0];
                inexact_d = s2_inx_q;
            end
        end
        sticky_inv_d = (bus.CLR_FLAGS ? 1'b0 : sticky_inv_q) | (out_valid_d & invalid_d);
        sticky_inx_d = (bus.CLR_FLAGS ? 1'b0 : sticky_inx_q) | (out_valid_d & inexact_d);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_q  <= 1'b0;
            z_q          <= 32'd0;
            invalid_q    <= 1'b0;
            inexact_q    <= 1'b0;
            sticky_inv_q <= 1'b0;
            sticky_inx_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            z_q          <= z_d;
            invalid_q    <= invalid_d;
            inexact_q    <= inexact_d;
            sticky_inv_q <= sticky_inv_d;
            sticky_inx_q <= sticky_inx_d;
        end
    end

    assign bus.OUT_VALID  = out_valid_q;
    assign bus.Z          = z_q;
    assign bus.INVALID    = invalid_q;
    assign bus.INEXACT    = inexact_q;
    assign bus.STICKY_INV = sticky_inv_q;
    assign bus.STICKY_INX = sticky_inx_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_f2i.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_fpu_f2i
// Purpose  : Self-checking bench for fpu_f2i, rounding and truncating builds.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_fpu_f2i;

    logic CLK = 1'b0;
    logic RESET;

    fpu_f2i_if ifr ();
    fpu_f2i_if ift ();

    fpu_f2i #(.RNE(1), .STAGES(3)) dut_r (.CLK(CLK), .RESET(RESET), .bus(ifr.slave));
    fpu_f2i #(.RNE(0), .STAGES(3)) dut_t (.CLK(CLK), .RESET(RESET), .bus(ift.slave));

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int vec_id   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact value of the float as m * 2^(u-23), rounded via quotient/remainder.
    function automatic void f2i_model(input logic [31:0] a, input bit rne,
                                      output logic [31:0] z, output logic inv, output logic inx);
        int u;
        longint unsigned m, q, r, half, one;
        bit huge, sgn;
        sgn = a[31]; z = 32'd0; inv = 1'b0; inx = 1'b0; huge = 1'b0; q = 0; one = 1;
        u = int'(a[30:23]) - 127;
        if (a[30:23] == 8'd0) return;
        if (a[30:23] == 8'hFF) begin
            inv = 1'b1;
            z = (a[22:0] != 23'd0 || !sgn) ? 32'h7FFF_FFFF : 32'h8000_0000;
            return;
        end
        m = {40'd0, 1'b1, a[22:0]};
        if (u >= 40) huge = 1'b1;
        else if (u >= 23) q = m << (u - 23);
        else if (23 - u >= 64) begin
            q = 0; inx = 1'b1;
        end else begin
            r    = m & ((one << (23 - u)) - 1);
            half = one << (22 - u);
            q    = m >> (23 - u);
            inx  = (r != 0);
            if (rne && (r > half || (r == half && q[0]))) q++;
        end
        if (huge || (!sgn && q >= 64'h8000_0000) || (sgn && q > 64'h8000_0000)) begin
            inv = 1'b1; inx = 1'b0;
            z = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            z = sgn ? 32'(-q) : 32'(q);
        end
    endfunction

    // Reference: 3-edge delay of accepted operands, outputs held between results.
    bit          dl_v [2];
    logic [31:0] dl_a [2];
    bit          m_ov;
    logic [31:0] m_z    [2];
    logic        m_inv  [2];
    logic        m_inx  [2];
    logic        m_sinv [2];
    logic        m_sinx [2];

    always @(posedge CLK) begin : model
        logic [31:0] z, oa;
        logic inv, inx;
        bit ov;
        if (RESET) begin
            dl_v[0] = 0; dl_v[1] = 0; m_ov = 0;
            for (int d = 0; d < 2; d++) begin
                m_z[d] = 0; m_inv[d] = 0; m_inx[d] = 0; m_sinv[d] = 0; m_sinx[d] = 0;
            end
        end else begin
            ov = dl_v[1]; oa = dl_a[1];
            dl_v[1] = dl_v[0]; dl_a[1] = dl_a[0];
            dl_v[0] = ifr.IN_VALID; dl_a[0] = ifr.A;
            m_ov = ov;
            for (int d = 0; d < 2; d++) begin
                if (ov) begin
                    f2i_model(oa, d == 0, z, inv, inx);
                    m_z[d] = z; m_inv[d] = inv; m_inx[d] = inx;
                end
                m_sinv[d] = (ifr.CLR_FLAGS ? 1'b0 : m_sinv[d]) | (ov & m_inv[d]);
                m_sinx[d] = (ifr.CLR_FLAGS ? 1'b0 : m_sinx[d]) | (ov & m_inx[d]);
            end
        end
    end

    always @(negedge CLK) begin
        if (check_en) begin
            chk("cycle_rne", 64'({ifr.OUT_VALID, ifr.Z, ifr.INVALID, ifr.INEXACT, ifr.STICKY_INV, ifr.STICKY_INX}),
                64'({m_ov, m_z[0], m_inv[0], m_inx[0], m_sinv[0], m_sinx[0]}));
            chk("cycle_trunc", 64'({ift.OUT_VALID, ift.Z, ift.INVALID, ift.INEXACT, ift.STICKY_INV, ift.STICKY_INX}),
                64'({m_ov, m_z[1], m_inv[1], m_inx[1], m_sinv[1], m_sinx[1]}));
        end
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic clr);
        ifr.IN_VALID = v; ifr.A = a; ifr.CLR_FLAGS = clr;
        ift.IN_VALID = v; ift.A = a; ift.CLR_FLAGS = clr;
    endtask

    // One isolated operand: pin the model to the literal, then the DUTs 3 edges later.
    task automatic run_vec(input logic [31:0] a,
                           input logic [31:0] zr, input logic ir, input logic xr,
                           input logic [31:0] zt, input logic it, input logic xt);
        logic [31:0] z;
        logic inv, inx;
        vec_id++;
        f2i_model(a, 1'b1, z, inv, inx);
        chk($sformatf("vec%0d_model_rne", vec_id), 64'({z, inv, inx}), 64'({zr, ir, xr}));
        f2i_model(a, 1'b0, z, inv, inx);
        chk($sformatf("vec%0d_model_trunc", vec_id), 64'({z, inv, inx}), 64'({zt, it, xt}));
        @(negedge CLK) drive(1'b1, a, 1'b0);
        @(negedge CLK) drive(1'b0, 32'd0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        chk($sformatf("vec%0d_dut_rne", vec_id),
            64'({ifr.OUT_VALID, ifr.Z, ifr.INVALID, ifr.INEXACT}), 64'({1'b1, zr, ir, xr}));
        chk($sformatf("vec%0d_dut_trunc", vec_id),
            64'({ift.OUT_VALID, ift.Z, ift.INVALID, ift.INEXACT}), 64'({1'b1, zt, it, xt}));
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge CLK);
        check_en = 1'b1;
        chk("reset_rne", 64'({ifr.OUT_VALID, ifr.Z, ifr.INVALID, ifr.INEXACT, ifr.STICKY_INV, ifr.STICKY_INX}), 64'd0);
        chk("reset_trunc", 64'({ift.OUT_VALID, ift.Z, ift.INVALID, ift.INEXACT, ift.STICKY_INV, ift.STICKY_INX}), 64'd0);
        RESET = 1'b0;

        //        A             Z(RNE)        INV   INX   Z(trunc)      INV   INX
        run_vec(32'h3FC0_0000, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b1);
        run_vec(32'h4020_0000, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b1);
        run_vec(32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        run_vec(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 32'h7FFF_FF80, 1'b0, 1'b0);
        run_vec(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_vec(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        run_vec(32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
        run_vec(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_vec(32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_vec(32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        run_vec(32'h3F00_0001, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        run_vec(32'h3EFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        run_vec(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        run_vec(32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        run_vec(32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        run_vec(32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, 32'hFFFF_FF85, 1'b0, 1'b0);
        run_vec(32'h5F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        run_vec(32'hDF00_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
        run_vec(32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 32'h0080_0001, 1'b0, 1'b0);
        run_vec(32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0, 1'b0, 32'h00FF_FFFF, 1'b0, 1'b0);
        run_vec(32'h4AFF_FFFF, 32'h0080_0000, 1'b0, 1'b1, 32'h007F_FFFF, 1'b0, 1'b1);
        run_vec(32'h3FE0_0000, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b1);
        run_vec(32'hBFC0_0000, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // back-to-back operands across the exponent range, with gaps and clears
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK) drive((i % 5) != 3, {i[0], 8'(118 + i), 23'(i * 32'h009E_3779)}, (i % 7) == 6);
        end
        @(negedge CLK) drive(1'b0, 32'd0, 1'b0);
        repeat (4) @(negedge CLK);

        // sticky: clear on the same edge as a NaN result keeps the flag
        @(negedge CLK) drive(1'b0, 32'd0, 1'b1);
        @(negedge CLK) drive(1'b1, 32'h7FC0_0000, 1'b0);
        @(negedge CLK) drive(1'b0, 32'd0, 1'b0);
        @(negedge CLK) drive(1'b0, 32'd0, 1'b1);
        @(negedge CLK);
        chk("sticky_set_with_clear", 64'({ifr.OUT_VALID, ifr.INVALID, ifr.STICKY_INV, ifr.STICKY_INX}), 64'(4'b1110));
        drive(1'b0, 32'd0, 1'b1);
        @(negedge CLK) drive(1'b0, 32'd0, 1'b0);
        chk("sticky_cleared", 64'({ifr.OUT_VALID, ifr.STICKY_INV, ift.STICKY_INV}), 64'd0);

        // pipeline: 1,1,0,1 then reset one cycle after the 4th operand
        @(negedge CLK) drive(1'b1, 32'h3F80_0000, 1'b0);
        @(negedge CLK) drive(1'b1, 32'h4000_0000, 1'b0);
        @(negedge CLK) drive(1'b0, 32'h4040_0000, 1'b0);
        @(negedge CLK) drive(1'b1, 32'h4040_0000, 1'b0);
        chk("pipe_out1", 64'({ifr.OUT_VALID, ifr.Z, ifr.INVALID, ifr.INEXACT}), 64'({1'b1, 32'd1, 2'b00}));
        @(negedge CLK) drive(1'b0, 32'd0, 1'b0);
        RESET = 1'b1;
        chk("pipe_out2", 64'({ifr.OUT_VALID, ifr.Z, ifr.INVALID, ifr.INEXACT}), 64'({1'b1, 32'd2, 2'b00}));
        @(negedge CLK);
        RESET = 1'b0;
        chk("pipe_reset", 64'({ifr.OUT_VALID, ifr.Z, ifr.INVALID, ifr.INEXACT, ifr.STICKY_INV, ifr.STICKY_INX}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk($sformatf("pipe_dropped%0d", i), 64'({ifr.OUT_VALID, ift.OUT_VALID, ifr.Z}), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
